// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding and load-use hazard detection over a shadow pipeline of in-flight writers.
// Optional saturating stall counter enabled by defining FORWARDING_STALL_COUNTER_EN.
module forwarding_hazard_unit #(
   parameter int NUM_RS     = 2,
   parameter int NUM_STAGES = 3,
   parameter int REG_ADDR_W = 5,
   parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
   input  logic                             clock,
   input  logic                             reset_n,
   input  logic                             id_valid,
   input  logic                             id_reg_we,
   input  logic [REG_ADDR_W-1:0]            id_rd,
   input  logic [SEL_W-1:0]                 id_ready_stage,
   input  logic [NUM_RS-1:0][REG_ADDR_W-1:0] id_rs,
   input  logic [NUM_RS-1:0]                id_rs_used,
   input  logic                             flush,
   input  logic                             stall_ext,
   output logic [NUM_RS-1:0][SEL_W-1:0]     forward_sel,
   output logic                             hazard_stall
`ifdef FORWARDING_STALL_COUNTER_EN
   ,
   output logic [31:0]                      stall_cycles
`endif
);

   typedef struct packed {
      logic                  valid;
      logic                  we;
      logic [REG_ADDR_W-1:0] rd;
      logic [SEL_W-1:0]      rdy;
   } entry_t;

   // Index 0 of the shadow arrays corresponds to stage 1 (EX).
   entry_t            entry_q [NUM_STAGES];
   entry_t            entry_d [NUM_STAGES];
   logic [NUM_RS-1:0] raw_stall_s;
   logic              accept_s;

   // Youngest-producer search per operand; the last stage is treated as always ready.
   always_comb begin : operand_match
      logic found;
      found       = 1'b0;
      forward_sel = '0;
      raw_stall_s = '0;
      for (int i = 0; i < NUM_RS; i++) begin
         found = 1'b0;
         for (int k = 0; k < NUM_STAGES; k++) begin
            if (!found && entry_q[k].valid && entry_q[k].we &&
                (entry_q[k].rd == id_rs[i]) && (id_rs[i] != {REG_ADDR_W{1'b0}}) &&
                id_rs_used[i]) begin
               found = 1'b1;
               if ((SEL_W'(k + 1) >= entry_q[k].rdy) || (k == NUM_STAGES - 1)) begin
                  forward_sel[i] = SEL_W'(k + 1);
               end else begin
                  raw_stall_s[i] = 1'b1;
               end
            end else begin
               found = found;
            end
         end
      end
   end

   assign hazard_stall = (|raw_stall_s) & ~flush & id_valid;
   assign accept_s     = id_valid & ~hazard_stall & ~flush;

   // Shadow pipeline advance; a frozen pipeline holds every entry.
   always_comb begin
      for (int k = 0; k < NUM_STAGES; k++) begin
         entry_d[k] = entry_q[k];
      end
      if (!stall_ext) begin
         if (accept_s) begin
            entry_d[0].valid = 1'b1;
            entry_d[0].we    = id_reg_we;
            entry_d[0].rd    = id_rd;
            entry_d[0].rdy   = id_ready_stage;
         end else begin
            entry_d[0] = '0;
         end
         for (int k = 1; k < NUM_STAGES; k++) begin
            entry_d[k] = entry_q[k-1];
         end
      end else begin
         entry_d[0] = entry_q[0];
      end
   end

   // Shadow entry registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            entry_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            entry_q[k] <= entry_d[k];
         end
      end
   end

`ifdef FORWARDING_STALL_COUNTER_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] stall_cnt_d;

   // Saturating count of cycles in which a hazard bubble actually enters the pipe.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (hazard_stall && !stall_ext && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Stall counter register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed scoreboard bench for forwarding_hazard_unit (default 2 operands, 3 stages).
// Stall counter checks are compiled in when FORWARDING_STALL_COUNTER_EN is defined.
module tb_forwarding_hazard_unit;

   logic            clock;
   logic            reset_n;
   logic            id_valid;
   logic            id_reg_we;
   logic [4:0]      id_rd;
   logic [1:0]      id_ready_stage;
   logic [1:0][4:0] id_rs;
   logic [1:0]      id_rs_used;
   logic            flush;
   logic            stall_ext;
   logic [1:0][1:0] forward_sel;
   logic            hazard_stall;
`ifdef FORWARDING_STALL_COUNTER_EN
   logic [31:0]     stall_cycles;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0] f0;
      logic [1:0] f1;
      logic       hz;
      string      tag;
   } exp_t;

   exp_t sb_q[$];

   forwarding_hazard_unit dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .id_valid       (id_valid),
      .id_reg_we      (id_reg_we),
      .id_rd          (id_rd),
      .id_ready_stage (id_ready_stage),
      .id_rs          (id_rs),
      .id_rs_used     (id_rs_used),
      .flush          (flush),
      .stall_ext      (stall_ext),
      .forward_sel    (forward_sel),
      .hazard_stall   (hazard_stall)
`ifdef FORWARDING_STALL_COUNTER_EN
      ,
      .stall_cycles   (stall_cycles)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic set_id(input logic v, input logic we, input logic [4:0] rd,
                         input logic [1:0] rdy, input logic [4:0] rs0,
                         input logic [4:0] rs1, input logic [1:0] used,
                         input logic fl, input logic sx);
      id_valid       = v;
      id_reg_we      = we;
      id_rd          = rd;
      id_ready_stage = rdy;
      id_rs[0]       = rs0;
      id_rs[1]       = rs1;
      id_rs_used     = used;
      flush          = fl;
      stall_ext      = sx;
   endtask

   task automatic expect_out(input string tag, input logic [1:0] f0,
                             input logic [1:0] f1, input logic hz);
      exp_t e;
      e.f0  = f0;
      e.f1  = f1;
      e.hz  = hz;
      e.tag = tag;
      sb_q.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      #1;
      checks++;
      assert (sb_q.size() != 0) else begin
         errors++;
         $error("FAIL scoreboard_empty got 0 entries want 1");
      end
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         checks++;
         assert (forward_sel[0] === e.f0) else begin
            errors++;
            $error("FAIL %s fwd0 got %0d want %0d", e.tag, forward_sel[0], e.f0);
         end
         checks++;
         assert (forward_sel[1] === e.f1) else begin
            errors++;
            $error("FAIL %s fwd1 got %0d want %0d", e.tag, forward_sel[1], e.f1);
         end
         checks++;
         assert (hazard_stall === e.hz) else begin
            errors++;
            $error("FAIL %s hazard got %0b want %0b", e.tag, hazard_stall, e.hz);
         end
      end
   endtask

   task automatic check_cnt(input string tag, input int unsigned exp_cnt);
`ifdef FORWARDING_STALL_COUNTER_EN
      checks++;
      assert (stall_cycles === exp_cnt) else begin
         errors++;
         $error("FAIL %s stall_cycles got %0d want %0d", tag, stall_cycles, exp_cnt);
      end
`else
      if (tag.len() == 0) begin
         $display("note: empty tag for count %0d", exp_cnt);
      end
`endif
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic step(input string tag, input logic v, input logic we,
                       input logic [4:0] rd, input logic [1:0] rdy,
                       input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [1:0] used, input logic fl, input logic sx,
                       input logic [1:0] f0, input logic [1:0] f1, input logic hz);
      set_id(v, we, rd, rdy, rs0, rs1, used, fl, sx);
      expect_out(tag, f0, f1, hz);
      check_out();
      tick();
   endtask

   initial begin
      reset_n = 1'b0;
      set_id(1'b0, 1'b0, 5'd0, 2'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      #2;
      expect_out("reset", 2'd0, 2'd0, 1'b0);
      check_out();
      check_cnt("reset", 0);
      @(negedge clock);
      reset_n = 1'b1;

      // ALU producer x5 then readers at increasing distance
      step("alu_issue", 1'b1, 1'b1, 5'd5, 2'd1, 5'd1, 5'd2, 2'b11, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
      step("alu_d1",    1'b1, 1'b0, 5'd0, 2'd0, 5'd5, 5'd0, 2'b11, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0);
      step("alu_d2",    1'b1, 1'b0, 5'd0, 2'd0, 5'd5, 5'd0, 2'b01, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0);
      step("alu_d3",    1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 5'd5, 2'b10, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0);

      // Load-use on rs2
      step("lw_issue",  1'b1, 1'b1, 5'd7, 2'd2, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
      check_cnt("lu_before", 0);
      step("lu_stall",  1'b1, 1'b1, 5'd8, 2'd1, 5'd0, 5'd7, 2'b10, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
      check_cnt("lu_after", 1);
      step("lu_fwd",    1'b1, 1'b1, 5'd8, 2'd1, 5'd0, 5'd7, 2'b10, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0);

      // Youngest producer wins; x0 never forwards
      step("x3_old",    1'b1, 1'b1, 5'd3, 2'd1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
      step("x0_write",  1'b1, 1'b1, 5'd0, 2'd1, 5'd3, 5'd0, 2'b01, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0);
      step("x3_new",    1'b1, 1'b1, 5'd3, 2'd1, 5'd0, 5'd0, 2'b10, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
      step("youngest",  1'b1, 1'b0, 5'd0, 2'd0, 5'd3, 5'd0, 2'b11, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0);

      // stall_ext freezes a load-use for three cycles
      step("lw2_issue", 1'b1, 1'b1, 5'd7, 2'd2, 5'd3, 5'd0, 2'b01, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0);
      check_cnt("ext_before", 1);
      step("ext_1",     1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 5'd7, 2'b10, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1);
      step("ext_2",     1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 5'd7, 2'b10, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1);
      step("ext_3",     1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 5'd7, 2'b10, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1);
      check_cnt("ext_held", 1);
      step("ext_rel",   1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 5'd7, 2'b10, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
      check_cnt("ext_after", 2);
      step("ext_fwd",   1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 5'd7, 2'b10, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0);

      // Flush beats a load-use hazard and leaves a bubble
      step("lw3_issue", 1'b1, 1'b1, 5'd9, 2'd2, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
      step("flush_hz",  1'b1, 1'b1, 5'd10, 2'd1, 5'd9, 5'd0, 2'b01, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
      check_cnt("flush_cnt", 2);
      step("flush_bub", 1'b1, 1'b0, 5'd0, 2'd0, 5'd10, 5'd9, 2'b11, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0);

      // Three writers in flight, then asynchronous reset
      step("w11",       1'b1, 1'b1, 5'd11, 2'd1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
      step("w12",       1'b1, 1'b1, 5'd12, 2'd1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
      step("w13",       1'b1, 1'b1, 5'd13, 2'd1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
      set_id(1'b1, 1'b0, 5'd0, 2'd0, 5'd11, 5'd12, 2'b11, 1'b0, 1'b0);
      expect_out("inflight", 2'd3, 2'd2, 1'b0);
      check_out();
      reset_n = 1'b0;
      expect_out("async_rst", 2'd0, 2'd0, 1'b0);
      check_out();
      check_cnt("async_rst", 0);
      tick();
      reset_n = 1'b1;
      expect_out("post_rst", 2'd0, 2'd0, 1'b0);
      check_out();
      check_cnt("post_rst", 0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/forwarding_hazard_unit.md
# forwarding_hazard_unit

Parametrised forwarding and load-use hazard unit for the pipelined core, replacing fixed EX/MEM/WB forwarding decisions with a configurable depth and operand count. It keeps a shadow pipeline of in-flight register writers, one entry per stage after ID. Each cycle it picks, for every ID-stage source operand, the youngest stage holding a ready result, or requests a stall when that result is not yet produced. It sits beside the ID stage and drives the operand bypass multiplexers and the ID/EX stall/bubble control.

## Interface
Parameters:
- NUM_RS, 2, number of source operands checked per instruction
- NUM_STAGES, 3, post-ID stages tracked (1 = EX ... NUM_STAGES = WB)
- REG_ADDR_W, 5, register address width
- SEL_W, $clog2(NUM_STAGES+1), width of stage indices and forward selects

Ports:
- clock  in  1  core clock
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- id_valid  in  1  valid instruction in ID
- id_reg_we  in  1  ID instruction writes rd
- id_rd  in  REG_ADDR_W  ID destination register
- id_ready_stage  in  SEL_W  first stage (1..NUM_STAGES) whose output carries the result (ALU = 1, load = 2)
- id_rs  in  NUM_RS x REG_ADDR_W  ID source registers
- id_rs_used  in  NUM_RS  operand actually read
- flush  in  1  kill the ID instruction (branch/trap)
- stall_ext  in  1  freeze the whole pipeline (memory wait)
- forward_sel  out  NUM_RS x SEL_W  0 = register file, k = bypass from stage k
- hazard_stall  out  1  hold PC/ID and insert a bubble into stage 1

## Operation
- Shadow entry e[k], k = 1..NUM_STAGES, holds {valid, we, rd, ready_stage}.
- Advance when stall_ext = 0:
  - e[k] <= e[k-1] for k >= 2.
  - e[1] <= the ID fields when id_valid & ~hazard_stall & ~flush; otherwise a bubble (valid = 0).
- stall_ext = 1: all entries hold, regardless of flush or hazard_stall.
- Match for operand i: valid & we & rd == id_rs[i] & rd != 0 & id_rs_used[i].
- Per operand, take the smallest k with a match (the youngest producer). Older matches are ignored.
  - No match: forward_sel[i] = 0.
  - Match and k >= e[k].ready_stage: forward_sel[i] = k.
  - Match and k < e[k].ready_stage: operand is not ready; forward_sel[i] = 0; raise raw_stall.
- hazard_stall = OR over operands of raw_stall, AND ~flush, AND id_valid.
- Register x0 never forwards and never stalls.
- Outputs are combinational from the shadow registers and the current ID inputs.

## Timing
- Reset: all e[k].valid = 0, forward_sel = 0, hazard_stall = 0, stall counter = 0.
- Forward decision has zero latency, same cycle as the ID inputs.
- Load (ready_stage = 2) followed by a dependent instruction:
  - Cycle n, load in e[1]: hazard_stall = 1 for one cycle.
  - Cycle n+1, load in e[2]: forward_sel = 2.
- ALU producer (ready_stage = 1) followed by a dependent instruction: no stall; forward_sel = 1.
- A producer in stage NUM_STAGES is always ready. WB-stage forwarding is always honoured.
- Simultaneous events:
  - flush with a hazard: flush wins; hazard_stall = 0; a bubble enters e[1].
  - stall_ext with a hazard: hazard_stall may be asserted, but nothing moves.
- Reset asserted mid-operation clears every entry asynchronously. The first cycle after release has no forwarding and no stalls.

## Configuration
- FORWARDING_STALL_COUNTER_EN defined:
  - Adds output `stall_cycles`, out, 32 bits: count of cycles with hazard_stall & ~stall_ext.
  - Saturates at 32'hFFFF_FFFF; reset value 0.
- Not defined: the port and the counter are absent; all other behaviour is identical.

## Test plan
- ALU dependency: add x5 (ready_stage 1) issues, next ID has rs1 = x5 -> forward_sel[0] = 1, hazard_stall = 0. One cycle later, an instruction reading x5 gets forward_sel = 2; the next gets 3.
- Load-use: lw x7 (ready_stage 2), next ID reads rs2 = x7 -> hazard_stall = 1 for exactly 1 cycle, then forward_sel[1] = 2. Stall counter (macro on) = 1.
- Youngest wins: x3 written in e[1] and in e[3], ID reads x3 -> forward_sel = 1. Operand reading x0 with a pending x0 write -> forward_sel = 0, no stall.
- stall_ext held 3 cycles during a load-use -> entries unchanged, hazard_stall stays 1, counter unchanged. After release: 1 stall cycle, then forward_sel = 2.
- flush together with a load-use hazard -> hazard_stall = 0. e[1] is a bubble next cycle, so a later reader of that rd gets forward_sel = 0.
- reset_n pulsed low while three writers are in flight -> all forward_sel = 0, hazard_stall = 0, counter = 0 immediately, without a clock edge.
